// File: rtl/elevador_pkg.sv
// Shared constants, FSM state type and entry helpers for the elevator content-RAM scanner.
package elevador_pkg;

    localparam int RAM_DEPTH = 8;
    localparam int ENTRY_W   = 4;
    localparam int FIELD_W   = 2;

    localparam logic [ENTRY_W-1:0] EMPTY_ENTRY = 4'b0000;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FLUSH,
        DONE
    } state_t;

    function automatic logic is_empty(input logic [ENTRY_W-1:0] entry);
        return entry == EMPTY_ENTRY;
    endfunction

endpackage

// File: rtl/varredor_conteudo_elevador_if.sv
// Read port of the elevator content RAM: scanner drives the address, RAM returns the entry fields.
interface varredor_conteudo_elevador_if #(
    parameter int ADDR_W = 4
);
    import elevador_pkg::*;

    logic [ADDR_W-1:0]  addr;
    logic [FIELD_W-1:0] tipo_objeto;
    logic [FIELD_W-1:0] destino_objeto;

    modport master (
        output addr,
        input  tipo_objeto,
        input  destino_objeto
    );

    modport slave (
        input  addr,
        output tipo_objeto,
        output destino_objeto
    );
endinterface

// File: rtl/acumulador_varredura.sv
// Per-entry accumulation for one scan: occupancy, unload count and first-valid destination.
// Outputs are the post-capture values so a capture on the final edge is already included.
module acumulador_varredura
    import elevador_pkg::*;
#(
    parameter int DEPTH = RAM_DEPTH,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               clear_n,
    input  logic               clear,
    input  logic               capture,
    input  logic [ENTRY_W-1:0] entry,
    input  logic [FIELD_W-1:0] andar,
    output logic [CNT_W-1:0]   ocupados,
    output logic [CNT_W-1:0]   qtd_andar,
    output logic [FIELD_W-1:0] prox_destino,
    output logic               prox_valido
);

    logic [CNT_W-1:0]   ocupados_reg, ocupados_next;
    logic [CNT_W-1:0]   qtd_reg, qtd_next;
    logic [FIELD_W-1:0] prox_destino_reg, prox_destino_next;
    logic               prox_valido_reg, prox_valido_next;
    logic [FIELD_W-1:0] destino;
    logic               hit;

    assign destino = entry[FIELD_W-1:0];
    assign hit     = capture && !is_empty(entry);

    always_comb begin
        ocupados_next     = ocupados_reg;
        qtd_next          = qtd_reg;
        prox_destino_next = prox_destino_reg;
        prox_valido_next  = prox_valido_reg;
        if (hit) begin
            if (ocupados_reg != CNT_W'(DEPTH))
                ocupados_next = ocupados_reg + 1'b1;
            if (destino == andar && qtd_reg != CNT_W'(DEPTH))
                qtd_next = qtd_reg + 1'b1;
            // Only the lowest-index occupied slot defines the next destination.
            if (!prox_valido_reg) begin
                prox_destino_next = destino;
                prox_valido_next  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n || clear) begin
            ocupados_reg     <= '0;
            qtd_reg          <= '0;
            prox_destino_reg <= '0;
            prox_valido_reg  <= 1'b0;
        end else begin
            ocupados_reg     <= ocupados_next;
            qtd_reg          <= qtd_next;
            prox_destino_reg <= prox_destino_next;
            prox_valido_reg  <= prox_valido_next;
        end
    end

    assign ocupados     = ocupados_next;
    assign qtd_andar    = qtd_next;
    assign prox_destino = prox_destino_next;
    assign prox_valido  = prox_valido_next;

endmodule

// File: rtl/varredor_conteudo_elevador.sv
// Sweeps the content RAM on start and publishes occupancy / unload / next-destination results.
// Optional macro VARREDURA_CONTINUA_EN: rescan back-to-back forever after the first start.
module varredor_conteudo_elevador
    import elevador_pkg::*;
#(
    parameter int DEPTH  = RAM_DEPTH,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 4
) (
    input  logic                 clk,
    input  logic                 clear_n,
    input  logic                 start,
    input  logic [FIELD_W-1:0]   andar_atual,
    varredor_conteudo_elevador_if.master ram,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     ocupados,
    output logic [CNT_W-1:0]     qtd_andar,
    output logic [FIELD_W-1:0]   prox_destino,
    output logic                 prox_valido,
    output logic                 tem_vaga,
    output logic                 tem_descarga
);

    state_t             state_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [FIELD_W-1:0] andar_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [CNT_W-1:0]   ocupados_reg;
    logic [CNT_W-1:0]   qtd_andar_reg;
    logic [FIELD_W-1:0] prox_destino_reg;
    logic               prox_valido_reg;
    logic               tem_vaga_reg;
    logic               tem_descarga_reg;

    logic               acc_clear;
    logic               acc_capture;
    logic [CNT_W-1:0]   acc_ocupados;
    logic [CNT_W-1:0]   acc_qtd;
    logic [FIELD_W-1:0] acc_prox_destino;
    logic               acc_prox_valido;

    // Read data lags addr by one edge, so slot 0 arrives while addr already shows 1.
    assign acc_capture = (state_reg == SCAN && addr_reg != '0) || state_reg == FLUSH;

`ifdef VARREDURA_CONTINUA_EN
    assign acc_clear = (state_reg == IDLE && start) || state_reg == FLUSH;
`else
    assign acc_clear = state_reg == IDLE && start;
`endif

    acumulador_varredura #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_acumulador (
        .clk          (clk),
        .clear_n      (clear_n),
        .clear        (acc_clear),
        .capture      (acc_capture),
        .entry        ({ram.tipo_objeto, ram.destino_objeto}),
        .andar        (andar_reg),
        .ocupados     (acc_ocupados),
        .qtd_andar    (acc_qtd),
        .prox_destino (acc_prox_destino),
        .prox_valido  (acc_prox_valido)
    );

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_reg        <= IDLE;
            addr_reg         <= '0;
            andar_reg        <= '0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            ocupados_reg     <= '0;
            qtd_andar_reg    <= '0;
            prox_destino_reg <= '0;
            prox_valido_reg  <= 1'b0;
            tem_vaga_reg     <= 1'b1;
            tem_descarga_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    addr_reg <= '0;
                    if (start) begin
                        state_reg <= SCAN;
                        andar_reg <= andar_atual;
                        busy_reg  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (addr_reg == ADDR_W'(DEPTH - 1)) begin
                        addr_reg  <= '0;
                        state_reg <= FLUSH;
                    end else begin
                        addr_reg <= addr_reg + 1'b1;
                    end
                end
                FLUSH: begin
                    ocupados_reg     <= acc_ocupados;
                    qtd_andar_reg    <= acc_qtd;
                    prox_destino_reg <= acc_prox_destino;
                    prox_valido_reg  <= acc_prox_valido;
                    tem_vaga_reg     <= acc_ocupados < CNT_W'(DEPTH);
                    tem_descarga_reg <= acc_qtd != '0;
                    done_reg         <= 1'b1;
                    state_reg        <= DONE;
`ifdef VARREDURA_CONTINUA_EN
                    // DONE doubles as the addr-0 cycle of the next sweep.
                    andar_reg        <= andar_atual;
`endif
                end
                DONE: begin
`ifdef VARREDURA_CONTINUA_EN
                    addr_reg  <= ADDR_W'(1);
                    state_reg <= SCAN;
`else
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
`endif
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    addr_reg  <= '0;
                end
            endcase
        end
    end

    assign ram.addr     = addr_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign ocupados     = ocupados_reg;
    assign qtd_andar    = qtd_andar_reg;
    assign prox_destino = prox_destino_reg;
    assign prox_valido  = prox_valido_reg;
    assign tem_vaga     = tem_vaga_reg;
    assign tem_descarga = tem_descarga_reg;

endmodule

// File: tb/tb_varredor_conteudo_elevador.sv
// Scoreboard bench for varredor_conteudo_elevador: directed RAM images, monitor checks each done pulse.
module tb_varredor_conteudo_elevador;

    typedef struct {
        int oc;
        int qt;
        int pd;
        int pv;
        int tv;
        int td;
    } exp_t;

    logic       clk = 1'b0;
    logic       clear_n;
    logic       start;
    logic [1:0] andar;
    logic       busy, done, prox_valido, tem_vaga, tem_descarga;
    logic [3:0] ocupados, qtd_andar;
    logic [1:0] prox_destino;

    logic [3:0] mem [8];
    logic [3:0] rd_reg = 4'b0000;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t q[$];

    varredor_conteudo_elevador_if #(.ADDR_W(4)) ram_if ();

    varredor_conteudo_elevador dut (
        .clk          (clk),
        .clear_n      (clear_n),
        .start        (start),
        .andar_atual  (andar),
        .ram          (ram_if.master),
        .busy         (busy),
        .done         (done),
        .ocupados     (ocupados),
        .qtd_andar    (qtd_andar),
        .prox_destino (prox_destino),
        .prox_valido  (prox_valido),
        .tem_vaga     (tem_vaga),
        .tem_descarga (tem_descarga)
    );

    always #5 clk = ~clk;

    // Content RAM with one cycle of registered-address read latency.
    always @(posedge clk) rd_reg <= mem[ram_if.addr[2:0]];
    assign ram_if.tipo_objeto    = rd_reg[3:2];
    assign ram_if.destino_objeto = rd_reg[1:0];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                exp_t e;
                e = q.pop_front();
                $display("done: ocupados=%0d qtd_andar=%0d prox=%0d/%0d vaga=%0d descarga=%0d",
                         ocupados, qtd_andar, prox_destino, prox_valido, tem_vaga, tem_descarga);
                chk("ocupados", int'(ocupados), e.oc);
                chk("qtd_andar", int'(qtd_andar), e.qt);
                chk("prox_destino", int'(prox_destino), e.pd);
                chk("prox_valido", int'(prox_valido), e.pv);
                chk("tem_vaga", int'(tem_vaga), e.tv);
                chk("tem_descarga", int'(tem_descarga), e.td);
            end
        end
    end

    task automatic load_ram(input logic [31:0] img);
        for (int i = 0; i < 8; i++) mem[i] = img[31-4*i -: 4];
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_addr"}, int'(ram_if.addr), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_ocupados"}, int'(ocupados), 0);
        chk({tag, "_qtd_andar"}, int'(qtd_andar), 0);
        chk({tag, "_prox_destino"}, int'(prox_destino), 0);
        chk({tag, "_prox_valido"}, int'(prox_valido), 0);
        chk({tag, "_tem_vaga"}, int'(tem_vaga), 1);
        chk({tag, "_tem_descarga"}, int'(tem_descarga), 0);
    endtask

    // Called at a negedge; start is sampled at the following posedge (E0).
    task automatic run_scan(input logic [1:0] fl, input exp_t e, input bit restart);
        int done_seen = 0;
        int done_k    = 0;
        q.push_back(e);
        start = 1'b1;
        andar = fl;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = restart && (k == 3);
            if (restart && k == 3) andar = fl + 2'd1;
            if (k <= 8) chk("addr", int'(ram_if.addr), k - 1);
            if (k == 1 || k == 10) chk("busy_during_scan", int'(busy), 1);
            if (k == 11) chk("busy_after_scan", int'(busy), 0);
            if (done === 1'b1) begin
                done_seen++;
                if (done_k == 0) done_k = k;
            end
        end
        chk("done_count", done_seen, 1);
        chk("done_latency", done_k, 10);
    endtask

    initial begin
        int done_seen;
        clear_n = 1'b0;
        start   = 1'b0;
        andar   = 2'd0;
        load_ram(32'h0000_0000);
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        clear_n = 1'b1;
        @(negedge clk);

`ifdef VARREDURA_CONTINUA_EN
        begin
            int nd = 0;
            load_ram(32'h6D09_0000);
            q.push_back('{3, 2, 2, 1, 1, 1});
            q.push_back('{0, 0, 0, 0, 1, 0});
            q.push_back('{0, 0, 0, 0, 1, 0});
            start = 1'b1;
            andar = 2'd1;
            for (int k = 1; k <= 40 && nd < 3; k++) begin
                @(negedge clk);
                start = 1'b0;
                if (done === 1'b1) begin
                    chk("continuous_period", k, 10 + 9 * nd);
                    nd++;
                    if (nd == 1) load_ram(32'h0000_0000);
                end
                if (k > 1) chk("continuous_busy", int'(busy), 1);
            end
            chk("continuous_done_count", nd, 3);
            clear_n = 1'b0;
            @(negedge clk);
            clear_n = 1'b1;
        end
`else
        // Empty RAM.
        load_ram(32'h0000_0000);
        run_scan(2'd1, '{0, 0, 0, 0, 1, 0}, 1'b0);

        // Mixed contents: two objects for floor 1, first destination 2.
        load_ram(32'h6D09_0000);
        run_scan(2'd1, '{3, 2, 2, 1, 1, 1}, 1'b0);

        // Full RAM, counts reach DEPTH.
        load_ram(32'h7777_7777);
        run_scan(2'd3, '{8, 8, 3, 1, 0, 1}, 1'b0);

        // Only the last slot occupied: exercises the final-entry capture.
        load_ram(32'h0000_0008);
        run_scan(2'd0, '{1, 1, 0, 1, 1, 1}, 1'b0);

        // Restart attempt and floor change mid-scan are ignored.
        load_ram(32'h6D09_0000);
        run_scan(2'd1, '{3, 2, 2, 1, 1, 1}, 1'b1);

        // Reset mid-scan aborts with no done and reset-valued outputs.
        load_ram(32'h7777_7777);
        start = 1'b1;
        andar = 2'd3;
        done_seen = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 5) clear_n = 1'b0;
            if (k == 6) begin
                clear_n = 1'b1;
                check_reset_state("midscan_reset");
            end
            if (done === 1'b1) done_seen++;
        end
        chk("aborted_done_count", done_seen, 0);

        // A fresh start after the abort completes normally.
        run_scan(2'd0, '{8, 0, 3, 1, 0, 0}, 1'b0);
`endif

        repeat (3) @(negedge clk);
        chk("pending_results", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/varredor_conteudo_elevador.md
Name: varredor_conteudo_elevador

Overview:
- Read-side scanner for the elevator content RAM (8 slots; 4-bit entry = {tipo_objeto[1:0], destino_objeto[1:0]}; all-zero entry = empty slot).
- On a start pulse it sweeps the RAM read port (`addr` → registered-address read data) from slot 0 to DEPTH-1 and summarises occupancy.
- Summary outputs: free space, objects to unload at the current floor, next destination in FIFO order.
- Results feed the elevator control FSM for stop and load/unload decisions.

Parameters:
- DEPTH, 8, number of RAM slots scanned.
- ADDR_W, 4, width of the RAM address bus.
- CNT_W, 4, width of the count outputs; must hold DEPTH.

Ports:
- clk  in  1  rising-edge clock.
- clear_n  in  1  synchronous active-low reset; one clock; reset is synchronous and active-low.
- start  in  1  one-cycle request to begin a scan.
- andar_atual  in  2  current floor; sampled on the accepting edge.
- addr  out  ADDR_W  read address to the content RAM.
- tipo_objeto  in  2  RAM read data, tipo field.
- destino_objeto  in  2  RAM read data, destino field.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse: results updated.
- ocupados  out  CNT_W  number of non-empty slots.
- qtd_andar  out  CNT_W  non-empty slots with destino == sampled andar_atual.
- prox_destino  out  2  destino of the lowest-index non-empty slot.
- prox_valido  out  1  at least one non-empty slot exists.
- tem_vaga  out  1  ocupados < DEPTH.
- tem_descarga  out  1  qtd_andar != 0.

Behaviour:
- RAM read timing: read data reflects the `addr` value present at the previous rising edge, i.e. one cycle of read latency.
- FSM states: IDLE, SCAN, FLUSH, DONE.
- IDLE:
  - addr = 0, busy = 0.
  - start = 1 at an edge E0 → SCAN; latch andar_atual; clear the internal accumulators.
- SCAN:
  - addr = i in cycle i+1 after E0, for i = 0..DEPTH-1; the address increments every cycle with no stalls.
  - The entry for address i is captured at edge E(i+2).
  - After addr = DEPTH-1 has been driven → FLUSH.
- FLUSH:
  - One cycle capturing the final entry.
  - At E(DEPTH+1), registered outputs load from the accumulators → DONE.
- DONE:
  - done = 1 for exactly one cycle, i.e. after the 9th edge past E0 with DEPTH = 8; busy still 1.
  - Then → IDLE.
- busy is 1 in SCAN, FLUSH and DONE.
- Per captured entry:
  - Empty iff {tipo,destino} == 4'b0000.
  - If non-empty: ocupados_acc += 1.
  - If non-empty and destino == andar_latched: qtd_acc += 1.
  - The first non-empty entry sets the prox destination and the valid flag; later entries do not override it.
- Counts saturate at DEPTH; with CNT_W = 4 overflow cannot occur.
- Result outputs (ocupados, qtd_andar, prox_destino, prox_valido, tem_vaga, tem_descarga) hold their values between done pulses.
- start while busy: ignored; no restart, no queueing.
- andar_atual changes mid-scan: no effect; the latched value is used.
- RAM contents changing mid-scan (shift, write): not corrected; the result is a snapshot of whatever was read per slot.
- Reset values, forced whenever clear_n = 0 at an edge, including mid-scan (scan aborted, partial accumulators discarded, state → IDLE):
  - addr = 0, busy = 0, done = 0.
  - ocupados = 0, qtd_andar = 0, prox_destino = 0, prox_valido = 0.
  - tem_vaga = 1, tem_descarga = 0.

Optional Feature:
- Macro: VARREDURA_CONTINUA_EN.
- Defined: DONE → SCAN directly, restarting at addr 0 and re-latching andar_atual.
  - Results refresh every DEPTH+1 cycles.
  - busy stays 1 after the first start.
  - The start input only triggers the first scan.
- Undefined: behaviour exactly as above (DONE → IDLE; single scan per start).

Decomposition:
- Shared package `elevador_pkg`:
  - Constants: RAM depth 8, entry width 4, field widths 2, EMPTY_ENTRY = 4'b0000.
  - Typedef: FSM state enum.
  - Function: is_empty(entry).
- One natural sub-module, `acumulador_varredura`: per-entry accumulation (counts, first-valid capture) with clear and capture enables, instantiated once.

Test Plan:
- Empty RAM, start with andar_atual = 1 → done after 9 edges; ocupados = 0, prox_valido = 0, tem_vaga = 1, tem_descarga = 0; addr sequence 0..7 observed.
- RAM = {0110, 1101, 0000, 1001, 0000, 0000, 0000, 0000}, andar_atual = 1 → ocupados = 3, qtd_andar = 2, prox_destino = 2, prox_valido = 1, tem_vaga = 1, tem_descarga = 1.
- All 8 slots = 4'b0111, andar_atual = 3 → ocupados = 8, qtd_andar = 8, tem_vaga = 0, prox_destino = 3.
- Second start pulse 3 cycles into a scan, and andar_atual changed mid-scan → exactly one done pulse; result uses the floor sampled at start.
- clear_n = 0 at cycle 5 of a scan → all outputs at reset values next cycle; no done pulse; a new start completes normally.
- With VARREDURA_CONTINUA_EN, single start → done pulses every 9 cycles; a RAM change is reflected in the next result.
